// File: rtl/vending_dispenser.sv
// Vend sequencer downstream of the coin accumulator: samples credit on a selection,
// dispenses, returns change one unit coin at a time, then tells the accumulator to clear.
module vending_dispenser #(
  parameter int BITS          = 4,
  parameter int PRICE_A       = 3,
  parameter int PRICE_B       = 7,
  parameter int DISP_CYCLES   = 4,
  parameter int CHANGE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] credit,
  input  logic            sel_a,
  input  logic            sel_b,
  input  logic            cancel,
  output logic            dispense_a,
  output logic            dispense_b,
  output logic            coin_out,
  output logic            deny,
  output logic            clr_credit,
  output logic            busy,
  output logic [BITS-1:0] change_left,
  output logic [6:0]      display
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, CLEAR} state_t;

  localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int CW = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
  localparam logic [BITS-1:0] PA = BITS'(PRICE_A);
  localparam logic [BITS-1:0] PB = BITS'(PRICE_B);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CHANGE_CYCLES - 1);

  state_t          state_reg;
  logic [DW-1:0]   disp_cnt_reg;
  logic [CW-1:0]   div_cnt_reg;
  logic [3:0]      disp_val;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Idle shows the live credit; once a vend starts the customer watches the change.
  always_comb begin
    disp_val = (state_reg == IDLE) ? 4'(credit) : 4'(change_left);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      disp_cnt_reg <= '0;
      div_cnt_reg  <= '0;
      dispense_a   <= 1'b0;
      dispense_b   <= 1'b0;
      coin_out     <= 1'b0;
      deny         <= 1'b0;
      clr_credit   <= 1'b0;
      busy         <= 1'b0;
      change_left  <= '0;
      display      <= 7'b1000000;
    end else begin
      display    <= seg7(disp_val);
      coin_out   <= 1'b0;
      deny       <= 1'b0;
      clr_credit <= 1'b0;
      case (state_reg)
        IDLE: begin
          disp_cnt_reg <= '0;
          div_cnt_reg  <= '0;
          if (cancel) begin
            change_left <= credit;
            busy        <= 1'b1;
            state_reg   <= CHANGE;
          end else if (sel_a) begin
            if (credit >= PA) begin
              change_left <= credit - PA;
              dispense_a  <= 1'b1;
              busy        <= 1'b1;
              state_reg   <= VEND;
            end else begin
              deny <= 1'b1;
            end
          end else if (sel_b) begin
            if (credit >= PB) begin
              change_left <= credit - PB;
              dispense_b  <= 1'b1;
              busy        <= 1'b1;
              state_reg   <= VEND;
            end else begin
              deny <= 1'b1;
            end
          end
        end
        VEND: begin
          if (disp_cnt_reg == DISP_LAST) begin
            dispense_a <= 1'b0;
            dispense_b <= 1'b0;
            state_reg  <= CHANGE;
          end else begin
            disp_cnt_reg <= disp_cnt_reg + 1'b1;
          end
        end
        CHANGE: begin
          if (change_left == '0) begin
            clr_credit <= 1'b1;
            state_reg  <= CLEAR;
          end else if (div_cnt_reg == DIV_LAST) begin
            // Coin and decrement share an edge so change_left already shows the remainder.
            div_cnt_reg <= '0;
            coin_out    <= 1'b1;
            change_left <= change_left - BITS'(1);
            if (change_left == BITS'(1)) begin
              clr_credit <= 1'b1;
              state_reg  <= CLEAR;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        CLEAR: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_dispenser.sv
// Directed bench for vending_dispenser: per-vend expectations and per-coin change values
// are queued at stimulus time and compared as the outputs appear.
module tb_vending_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] credit;
  logic       sel_a, sel_b, cancel;
  logic       dispense_a, dispense_b, coin_out, deny, clr_credit, busy;
  logic [3:0] change_left;
  logic [6:0] display;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int disp_a;
    int disp_b;
    int coins;
    int clr;
    int deny;
  } txn_t;

  txn_t exp_q[$];
  int   coin_q[$];

  int n_disp_a = 0, n_disp_b = 0, n_coin = 0, n_clr = 0, n_deny = 0;
  int s_disp_a, s_disp_b, s_coin, s_clr, s_deny;
  int cyc = 0;
  int last_coin = 0;
  bit first_coin = 1'b1;

  vending_dispenser dut (
    .clk(clk), .rst(rst), .credit(credit), .sel_a(sel_a), .sel_b(sel_b),
    .cancel(cancel), .dispense_a(dispense_a), .dispense_b(dispense_b),
    .coin_out(coin_out), .deny(deny), .clr_credit(clr_credit), .busy(busy),
    .change_left(change_left), .display(display)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'b1000000;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_disp_a = n_disp_a; s_disp_b = n_disp_b; s_coin = n_coin;
    s_clr = n_clr; s_deny = n_deny;
  endtask

  task automatic expect_txn(input int a, input int b, input int c, input int d, input int e);
    txn_t t;
    t.disp_a = a; t.disp_b = b; t.coins = c; t.clr = d; t.deny = e;
    exp_q.push_back(t);
  endtask

  task automatic end_check(input string name);
    txn_t t;
    t = exp_q.pop_front();
    chk({name, "_disp_a_cycles"}, n_disp_a - s_disp_a, t.disp_a);
    chk({name, "_disp_b_cycles"}, n_disp_b - s_disp_b, t.disp_b);
    chk({name, "_coins"},         n_coin - s_coin,     t.coins);
    chk({name, "_clr_pulses"},    n_clr - s_clr,       t.clr);
    chk({name, "_deny_pulses"},   n_deny - s_deny,     t.deny);
    $display("txn %s: disp_a=%0d disp_b=%0d coins=%0d clr=%0d deny=%0d", name,
             n_disp_a - s_disp_a, n_disp_b - s_disp_b, n_coin - s_coin,
             n_clr - s_clr, n_deny - s_deny);
  endtask

  task automatic end_txn(input string name);
    for (int k = 0; k < 200; k++) begin
      step();
      if (busy === 1'b0) break;
    end
    chk({name, "_busy_drops"}, busy, 0);
    end_check(name);
  endtask

  // Monitor: counts output activity and scoreboards each returned coin.
  always @(negedge clk) begin
    cyc++;
    if (dispense_a === 1'b1) n_disp_a++;
    if (dispense_b === 1'b1) n_disp_b++;
    if (clr_credit === 1'b1) n_clr++;
    if (deny === 1'b1) n_deny++;
    if (busy !== 1'b1) first_coin = 1'b1;
    if (coin_out === 1'b1) begin
      n_coin++;
      if (coin_q.size() == 0) chk("coin_unexpected", 1, 0);
      else chk("coin_change_left", change_left, coin_q.pop_front());
      if (!first_coin) chk("coin_gap", cyc - last_coin, 2);
      first_coin = 1'b0;
      last_coin  = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; credit = '0; sel_a = 1'b0; sel_b = 1'b0; cancel = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_dispense", {dispense_a, dispense_b, coin_out, deny, clr_credit}, 0);
    chk("rst_change_left", change_left, 0);
    chk("rst_display", display, 7'b1000000);
    rst = 1'b0;
    step();

    // T1: credit 5, buy A -> change 2
    credit = 4'd5; step(); snap();
    expect_txn(4, 0, 2, 1, 0);
    coin_q.push_back(1); coin_q.push_back(0);
    sel_a = 1'b1; step(); sel_a = 1'b0;
    chk("t1_change_left", change_left, 2);
    chk("t1_busy", busy, 1);
    chk("t1_dispense_a", dispense_a, 1);
    step();
    chk("t1_display_change", display, seg(2));
    end_txn("t1");
    credit = 4'd0; step(); step();
    chk("t1_display_idle", display, seg(0));

    // T2: exact price for B -> no change
    credit = 4'd7; step(); snap();
    expect_txn(0, 4, 0, 1, 0);
    sel_b = 1'b1; step(); sel_b = 1'b0;
    chk("t2_change_left", change_left, 0);
    chk("t2_dispense_b", dispense_b, 1);
    end_txn("t2");

    // T3: insufficient credit with sel_a held
    credit = 4'd2; step(); snap();
    expect_txn(0, 0, 0, 0, 3);
    sel_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_deny", deny, 1);
      chk("t3_busy", busy, 0);
    end
    sel_a = 1'b0; step();
    chk("t3_deny_release", deny, 0);
    step();
    end_check("t3");

    // T4: cancel wins over both selections
    credit = 4'd10; step(); snap();
    expect_txn(0, 0, 10, 1, 0);
    for (int v = 9; v >= 0; v--) coin_q.push_back(v);
    cancel = 1'b1; sel_a = 1'b1; sel_b = 1'b1; step();
    cancel = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    chk("t4_change_left", change_left, 10);
    chk("t4_no_dispense", {dispense_a, dispense_b}, 0);
    end_txn("t4");

    // T5: inputs changed during a vend of A are ignored
    credit = 4'd12; step(); snap();
    expect_txn(4, 0, 9, 1, 0);
    for (int v = 8; v >= 0; v--) coin_q.push_back(v);
    sel_a = 1'b1; step(); sel_a = 1'b0;
    credit = 4'd15; sel_b = 1'b1; step(); step();
    chk("t5_change_held", change_left, 9);
    sel_b = 1'b0; cancel = 1'b1; step(); cancel = 1'b0;
    chk("t5_change_held2", change_left, 9);
    chk("t5_still_a", {dispense_a, dispense_b}, 2'b10);
    chk("t5_display_change", display, seg(9));
    end_txn("t5");
    credit = 4'd0; step();

    // T6: asynchronous reset in the middle of returning change
    credit = 4'd6; step(); snap();
    sel_a = 1'b1; step(); sel_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dispense_a !== 1'b1) break;
    end
    chk("t6_change_left", change_left, 3);
    chk("t6_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pulses", {dispense_a, dispense_b, coin_out, deny, clr_credit}, 0);
    chk("t6_rst_change_left", change_left, 0);
    chk("t6_rst_display", display, 7'b1000000);
    step(); rst = 1'b0; step(); step();
    chk("t6_idle_busy", busy, 0);
    chk("t6_no_coins", n_coin - s_coin, 0);
    chk("t6_no_clr", n_clr - s_clr, 0);
    $display("txn t6: reset mid-change, coins=%0d clr=%0d", n_coin - s_coin, n_clr - s_clr);

    chk("coin_queue_drained", coin_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
